// File: rtl/rgb_fader_pkg.sv
// Shared types, constants and the fixed-point scale helper for the RGB hue-wheel fader.
// Purely declarative: no latency, no flow control.
package rgb_fader_pkg;

  typedef enum logic [1:0] {
    MODE_RUN     = 2'd0,
    MODE_HOLD    = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_OFF     = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_HOLD    = 2'd2,
    ST_BREATHE = 2'd3
  } state_e;

  localparam int NUM_SEGS = 6;

  // (c*(eff+1))>>n: full scale on both operands returns full scale, zero stays zero.
  function automatic logic [31:0] scale(input logic [31:0] c, input logic [31:0] eff, input int n);
    scale = (c * (eff + 32'd1)) >> n;
  endfunction

endpackage

// File: rtl/rgb_pwm_chan.sv
// One active-low PWM channel: duty latched at period start (optional gamma via RGB_FADER_GAMMA_EN).
// Latency: 1 cycle from compare to pad flop; no backpressure, force_off wins immediately.
module rgb_pwm_chan
  import rgb_fader_pkg::*;
#(
  parameter int PWM_BITS = 8
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic [PWM_BITS-1:0] duty_in,
  input  logic [PWM_BITS-1:0] pwm_cnt,
  input  logic                pstart,
  input  logic                force_off,
  output logic                pad_n
);

  logic [PWM_BITS-1:0] duty_g;
  logic [PWM_BITS-1:0] duty_cur;
  logic [PWM_BITS-1:0] duty_d, duty_q;
  logic                pad_d, pad_q;

  always_comb begin
`ifdef RGB_FADER_GAMMA_EN
    duty_g = PWM_BITS'(scale(32'(duty_in), 32'(duty_in), PWM_BITS));
`else
    duty_g = duty_in;
`endif
    // The period-start cycle compares against the freshly latched value, not the stale one.
    duty_cur = pstart ? duty_g : duty_q;
    duty_d   = duty_cur;
    pad_d    = force_off ? 1'b1 : !(pwm_cnt < duty_cur);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      duty_q <= '0;
      pad_q  <= 1'b1;
    end else begin
      duty_q <= duty_d;
      pad_q  <= pad_d;
    end
  end

  assign pad_n = pad_q;

endmodule

// File: rtl/rgb_hue_fader.sv
// Six-segment hue-wheel RGB driver with global brightness, HOLD and BREATHE modes (gamma: RGB_FADER_GAMMA_EN).
// Latency: 1 cycle compare-to-pad, new colour from next PWM period; no backpressure.
module rgb_hue_fader
  import rgb_fader_pkg::*;
#(
  parameter  int PWM_BITS   = 8,
  parameter  int SEG_BITS   = 6,
  parameter  int STEP_TICKS = 31250,
  localparam int HUE_STEPS  = NUM_SEGS << SEG_BITS,
  localparam int HUE_W      = $clog2(HUE_STEPS)
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                en,
  input  logic [1:0]          mode,
  input  logic [PWM_BITS-1:0] brightness,
  output logic                RGB_R,
  output logic                RGB_G,
  output logic                RGB_B,
  output logic                LED,
  output logic [HUE_W-1:0]    hue,
  output logic                wrap
);

  localparam int                  TICK_W    = (STEP_TICKS > 1) ? $clog2(STEP_TICKS) : 1;
  localparam logic [PWM_BITS-1:0] PWM_MAX   = '1;
  localparam logic [HUE_W-1:0]    HUE_LAST  = HUE_W'(HUE_STEPS - 1);
  localparam logic [TICK_W-1:0]   TICK_LAST = TICK_W'(STEP_TICKS - 1);

  state_e              state_d, state_q;
  logic [TICK_W-1:0]   tick_d, tick_q;
  logic [HUE_W-1:0]    hue_d, hue_q;
  logic [PWM_BITS-1:0] env_d, env_q;
  logic                env_dn_d, env_dn_q;
  logic [PWM_BITS-1:0] pwm_d, pwm_q;
  logic                wrap_d, wrap_q;
  logic                led_d, led_q;

  logic                active, step, run_step, breathe_step, breathe_entry, force_off;
  logic                pstart;
  logic [SEG_BITS-1:0] pos;
  int                  seg;
  logic [PWM_BITS-1:0] ramp, c_r, c_g, c_b, eff, duty_r, duty_g, duty_b;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = ST_IDLE;
    if (en) begin
      case (mode_e'(mode))
        MODE_RUN:     state_d = ST_RUN;
        MODE_HOLD:    state_d = ST_HOLD;
        MODE_BREATHE: state_d = ST_BREATHE;
        default:      state_d = ST_IDLE;
      endcase
    end
  end

  // Ticks are qualified by the current state, so a mode change on a tick cycle uses the old state.
  always_comb begin
    active        = en && (state_q != ST_IDLE);
    step          = active && (tick_q == TICK_LAST);
    run_step      = step && (state_q == ST_RUN);
    breathe_step  = step && (state_q == ST_BREATHE);
    breathe_entry = (state_d == ST_BREATHE) && (state_q != ST_BREATHE);
    force_off     = (state_q == ST_IDLE) || (state_d == ST_IDLE);
  end

  always_comb begin
    tick_d   = tick_q;
    hue_d    = hue_q;
    env_d    = env_q;
    env_dn_d = env_dn_q;
    wrap_d   = 1'b0;
    led_d    = led_q;

    if (active) tick_d = step ? '0 : tick_q + 1'b1;

    if (run_step) begin
      if (hue_q == HUE_LAST) begin
        hue_d  = '0;
        wrap_d = 1'b1;
        led_d  = !led_q;
      end else begin
        hue_d = hue_q + 1'b1;
      end
    end

    // At each endpoint only the direction flips, so that value lasts one extra tick.
    if (breathe_entry) begin
      env_d    = '0;
      env_dn_d = 1'b0;
    end else if (breathe_step) begin
      if (!env_dn_q) begin
        if (env_q == PWM_MAX) env_dn_d = 1'b1;
        else                  env_d    = env_q + 1'b1;
      end else begin
        if (env_q == '0) env_dn_d = 1'b0;
        else             env_d    = env_q - 1'b1;
      end
    end

    pwm_d = (force_off || (pwm_q == PWM_MAX - 1'b1)) ? '0 : pwm_q + 1'b1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      tick_q   <= '0;
      hue_q    <= '0;
      env_q    <= '0;
      env_dn_q <= 1'b0;
      pwm_q    <= '0;
      wrap_q   <= 1'b0;
      led_q    <= 1'b1;
    end else begin
      tick_q   <= tick_d;
      hue_q    <= hue_d;
      env_q    <= env_d;
      env_dn_q <= env_dn_d;
      pwm_q    <= pwm_d;
      wrap_q   <= wrap_d;
      led_q    <= led_d;
    end
  end

  always_comb begin
    pos  = hue_q[SEG_BITS-1:0];
    seg  = int'(hue_q >> SEG_BITS);
    ramp = PWM_BITS'((32'(pos) * 32'(PWM_MAX)) >> SEG_BITS);
    c_r  = '0;
    c_g  = '0;
    c_b  = '0;
    case (seg)
      0: begin c_r = PWM_MAX;        c_g = ramp;           end
      1: begin c_r = PWM_MAX - ramp; c_g = PWM_MAX;        end
      2: begin c_g = PWM_MAX;        c_b = ramp;           end
      3: begin c_g = PWM_MAX - ramp; c_b = PWM_MAX;        end
      4: begin c_r = ramp;           c_b = PWM_MAX;        end
      5: begin c_r = PWM_MAX;        c_b = PWM_MAX - ramp; end
      default: ;
    endcase

    eff = (state_q == ST_BREATHE) ? PWM_BITS'(scale(32'(brightness), 32'(env_q), PWM_BITS))
                                  : brightness;
    duty_r = PWM_BITS'(scale(32'(c_r), 32'(eff), PWM_BITS));
    duty_g = PWM_BITS'(scale(32'(c_g), 32'(eff), PWM_BITS));
    duty_b = PWM_BITS'(scale(32'(c_b), 32'(eff), PWM_BITS));
    pstart = (pwm_q == '0);
  end

  rgb_pwm_chan #(.PWM_BITS(PWM_BITS)) u_chan_r (
    .CLK(CLK), .RST_N(RST_N), .duty_in(duty_r), .pwm_cnt(pwm_q),
    .pstart(pstart), .force_off(force_off), .pad_n(RGB_R)
  );

  rgb_pwm_chan #(.PWM_BITS(PWM_BITS)) u_chan_g (
    .CLK(CLK), .RST_N(RST_N), .duty_in(duty_g), .pwm_cnt(pwm_q),
    .pstart(pstart), .force_off(force_off), .pad_n(RGB_G)
  );

  rgb_pwm_chan #(.PWM_BITS(PWM_BITS)) u_chan_b (
    .CLK(CLK), .RST_N(RST_N), .duty_in(duty_b), .pwm_cnt(pwm_q),
    .pstart(pstart), .force_off(force_off), .pad_n(RGB_B)
  );

  assign hue  = hue_q;
  assign wrap = wrap_q;
  assign LED  = led_q;

endmodule

// File: tb/tb_rgb_hue_fader.sv
// Self-checking bench for rgb_hue_fader at PWM_BITS=4, SEG_BITS=2, STEP_TICKS=8.
module tb_rgb_hue_fader;

  localparam int MAXV = 15;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       en;
  logic [1:0] mode;
  logic [3:0] brightness;
  logic       RGB_R, RGB_G, RGB_B, LED, wrap;
  logic [4:0] hue;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  rgb_hue_fader #(.PWM_BITS(4), .SEG_BITS(2), .STEP_TICKS(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .en(en), .mode(mode), .brightness(brightness),
    .RGB_R(RGB_R), .RGB_G(RGB_G), .RGB_B(RGB_B), .LED(LED), .hue(hue), .wrap(wrap)
  );

  typedef struct {
    int h;
    int b;
    int r;
    int g;
    int bl;
  } vec_t;

  vec_t tbl[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
    end
  endtask

  // Red channel as a trapezoid over the 24-step wheel; green and blue are the same shape rotated.
  function automatic int wheel(input int x);
    int s = x / 4;
    int r = ((x % 4) * MAXV) / 4;
    if (s == 0 || s == 5) return MAXV;
    if (s == 1) return MAXV - r;
    if (s == 4) return r;
    return 0;
  endfunction

  function automatic int level(input int h, input int ch);
    return wheel((h - 8 * ch + 48) % 24);
  endfunction

  function automatic int gam(input int d);
`ifdef RGB_FADER_GAMMA_EN
    return (d * (d + 1)) / 16;
`else
    return d;
`endif
  endfunction

  function automatic int duty_of(input int c, input int b);
    return gam((c * (b + 1)) / 16);
  endfunction

  // Envelope after k ticks: triangle 0..15..0 with each endpoint held one extra tick.
  function automatic int env_at(input int k);
    int m = k % 32;
    if (m <= 15) return m;
    if (m == 16) return 15;
    return 31 - m;
  endfunction

  task automatic do_reset(input logic en_v, input logic [1:0] mode_v, input logic [3:0] b_v);
    @(negedge CLK);
    RST_N = 1'b0;
    en = en_v;
    mode = mode_v;
    brightness = b_v;
    repeat (3) @(negedge CLK);
    check("reset_rgb", {RGB_R, RGB_G, RGB_B}, 3'b111);
    check("reset_led", LED, 1);
    check("reset_hue", hue, 0);
    check("reset_wrap", wrap, 0);
    RST_N = 1'b1;
  endtask

  task automatic goto_hue(input int h);
    int guard = 0;
    mode = 2'd1;
    repeat (2) @(negedge CLK);
    if (int'(hue) != h) begin
      mode = 2'd0;
      while (int'(hue) != h && guard < 400) begin
        @(negedge CLK);
        guard++;
      end
      mode = 2'd1;
    end
    check("goto_hue", hue, h);
  endtask

  task automatic count_lows(input int ncyc, output int lr, output int lg, output int lb);
    lr = 0; lg = 0; lb = 0;
    repeat (ncyc) begin
      @(negedge CLK);
      lr += int'(!RGB_R);
      lg += int'(!RGB_G);
      lb += int'(!RGB_B);
    end
  endtask

  task automatic measure(input int h, input int b, input int er, input int eg, input int eb);
    int lr, lg, lb;
    goto_hue(h);
    brightness = 4'(b);
    repeat (35) @(negedge CLK);
    count_lows(15, lr, lg, lb);
    check("duty_r", lr, er);
    check("duty_g", lg, eg);
    check("duty_b", lb, eb);
    check("hold_hue", hue, h);
  endtask

  task automatic breathe_run(input int b);
    do_reset(1'b1, 2'd2, 4'(b));
    for (int n = 1; n <= 300; n++) begin
      int cnt, n0, e, eff, d, exp_r;
      @(negedge CLK);
      if (n == 1) begin
        exp_r = 1;
      end else begin
        cnt   = (n - 2) % 15;
        n0    = n - 1 - cnt;
        e     = env_at((n0 - 1) / 8);
        eff   = (b * (e + 1)) / 16;
        d     = duty_of(MAXV, eff);
        exp_r = (cnt < d) ? 0 : 1;
      end
      check("breathe_r", RGB_R, exp_r);
      check("breathe_hue", hue, 0);
    end
  endtask

  initial begin
    int lr, lg, lb, guard, c1, c2, h, b;
    logic prev;

    tbl[0] = '{1, 15, 15, 3, 0};
    tbl[1] = '{6, 15, 8, 15, 0};
    tbl[2] = '{6, 7, 4, 7, 0};
    tbl[3] = '{10, 15, 0, 15, 7};
    tbl[4] = '{13, 15, 0, 12, 15};
    tbl[5] = '{19, 3, 2, 0, 3};
    tbl[6] = '{21, 15, 15, 0, 12};
    tbl[7] = '{23, 0, 0, 0, 0};

    RST_N = 1'b0;
    en = 1'b0;
    mode = 2'd0;
    brightness = 4'd0;

    // Reset, release into RUN, full wheel with wrap pulse and LED toggle.
    do_reset(1'b1, 2'd0, 4'd15);
    for (int n = 1; n <= 200; n++) begin
      @(negedge CLK);
      check("run_hue", hue, ((n - 1) / 8) % 24);
      check("run_wrap", wrap, (n == 193) ? 1 : 0);
      check("run_led", LED, (n >= 193) ? 0 : 1);
      if (n == 1) check("release_rgb", {RGB_R, RGB_G, RGB_B}, 3'b111);
      if (n >= 2 && n <= 8) check("hue0_rgb", {RGB_R, RGB_G, RGB_B}, 3'b011);
    end

    for (int i = 0; i < 8; i++)
      measure(tbl[i].h, tbl[i].b, gam(tbl[i].r), gam(tbl[i].g), gam(tbl[i].bl));

    for (int i = 0; i < 6; i++) begin
      h = int'($urandom_range(0, 23));
      b = int'($urandom_range(0, 15));
      measure(h, b, duty_of(level(h, 0), b), duty_of(level(h, 1), b), duty_of(level(h, 2), b));
    end

    // Brightness change mid-period only takes effect at the next period start.
    goto_hue(6);
    brightness = 4'd15;
    repeat (35) @(negedge CLK);
    guard = 0;
    do begin
      prev = RGB_R;
      @(negedge CLK);
      guard++;
    end while (!(prev == 1'b1 && RGB_R == 1'b0) && guard < 40);
    check("period_edge_found", guard < 40, 1);
    brightness = 4'd7;
    c1 = int'(!RGB_R);
    repeat (14) begin
      @(negedge CLK);
      c1 += int'(!RGB_R);
    end
    count_lows(15, c2, lg, lb);
    check("old_period_r", c1, duty_of(8, 15));
    check("new_period_r", c2, duty_of(8, 7));

    // en drop, OFF, then restart from the same hue with the PWM counter at 0.
    brightness = 4'd15;
    repeat (35 + $urandom_range(0, 14)) @(negedge CLK);
    en = 1'b0;
    @(negedge CLK);
    check("en_off_rgb", {RGB_R, RGB_G, RGB_B}, 3'b111);
    check("en_off_hue", hue, 6);
    mode = 2'd3;
    repeat (3) @(negedge CLK);
    en = 1'b1;
    repeat (3) @(negedge CLK);
    check("mode_off_rgb", {RGB_R, RGB_G, RGB_B}, 3'b111);
    check("mode_off_hue", hue, 6);
    mode = 2'd1;
    @(negedge CLK);
    check("restart_first_rgb", {RGB_R, RGB_G, RGB_B}, 3'b111);
    @(negedge CLK);
    check("restart_r_on", RGB_R, 0);
    lr = 1; lg = int'(!RGB_G); lb = int'(!RGB_B);
    for (int k = 1; k < 15; k++) begin
      @(negedge CLK);
      lr += int'(!RGB_R);
      lg += int'(!RGB_G);
      lb += int'(!RGB_B);
    end
    check("restart_r", lr, duty_of(8, 15));
    check("restart_g", lg, duty_of(15, 15));
    check("restart_b", lb, 0);
    check("restart_hue", hue, 6);

    // Asynchronous reset between clock edges.
    @(posedge CLK);
    #2;
    RST_N = 1'b0;
    #1;
    check("async_rst_rgb", {RGB_R, RGB_G, RGB_B}, 3'b111);
    check("async_rst_hue", hue, 0);
    check("async_rst_led", LED, 1);
    check("async_rst_wrap", wrap, 0);

    breathe_run(15);
    breathe_run(int'($urandom_range(1, 14)));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
